// File: rtl/mem_responder_if.sv
// Bus bundle between a requester and the mem_responder.
//   req/wr/size/addr/wdata : request, driven by the master
//   rdata/busy/done/err    : response, driven by the responder (slave)
interface mem_responder_if;
   logic        req;
   logic        wr;
   logic [1:0]  size;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        busy;
   logic        done;
   logic        err;

   modport master (
      output req, wr, size, addr, wdata,
      input  rdata, busy, done, err
   );

   modport slave (
      input  req, wr, size, addr, wdata,
      output rdata, busy, done, err
   );
endinterface

// File: rtl/mem_responder.sv
// 256-byte little-endian memory with a fixed access latency.
// A request is captured in IDLE or DONE, waits LATENCY edges, then completes
// with a one-cycle done pulse. Addresses with addr[31:8] != 0 complete with
// err=1, write nothing and read back zero.
//   clk   : rising-edge clock
//   reset : synchronous, active-high; storage contents are not affected
//   bus   : mem_responder_if.slave (req/wr/size/addr/wdata in,
//           rdata/busy/done/err out, all outputs registered)
//
// state   | meaning
// --------+------------------------------------------------
// ST_IDLE | no access in flight, waiting for req
// ST_WAIT | access in flight, counter running down (busy=1)
// ST_DONE | completion cycle (done=1), may accept a new req
module mem_responder #(
   parameter int unsigned LATENCY = 2   // legal range 1..15
) (
   input  logic            clk,
   input  logic            reset,
   mem_responder_if.slave  bus
);

   localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t      state_q;
   logic [3:0]  cnt_q;
   logic        wr_q;
   logic [1:0]  size_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [31:0] rdata_q;
   logic        busy_q;
   logic        done_q;
   logic        err_q;

   logic [7:0]  mem_q [256];

   logic [7:0]  idx   [4];
   logic [3:0]  be;
   logic        oor;
   logic        finish;
   logic        commit;
   logic [31:0] rd_word;

   // Byte lanes wrap modulo 256 through the 8-bit add.
   always_comb begin
      for (int i = 0; i < 4; i++) begin
         idx[i] = addr_q[7:0] + 8'(i);
      end
   end

   always_comb begin
      be = 4'b1111;
      case (size_q)
         2'b01:   be = 4'b0011;
         2'b10:   be = 4'b0001;
         default: be = 4'b1111;
      endcase
   end

   assign oor     = |addr_q[31:8];
   assign finish  = (state_q == ST_WAIT) && (cnt_q == 4'd0);
   // A reset on the completing edge aborts the access, so it also blocks the write.
   assign commit  = finish && !reset && wr_q && !oor;
   assign rd_word = {mem_q[idx[3]], mem_q[idx[2]], mem_q[idx[1]], mem_q[idx[0]]};

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         wr_q    <= 1'b0;
         size_q  <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         err_q  <= 1'b0;
         case (state_q)
            ST_IDLE, ST_DONE: begin
               if (bus.req) begin
                  wr_q    <= bus.wr;
                  size_q  <= bus.size;
                  addr_q  <= bus.addr;
                  wdata_q <= bus.wdata;
                  cnt_q   <= LAT_M1;
                  busy_q  <= 1'b1;
                  state_q <= ST_WAIT;
               end else begin
                  state_q <= ST_IDLE;
               end
            end
            ST_WAIT: begin
               if (cnt_q != 4'd0) begin
                  cnt_q <= cnt_q - 4'd1;
               end else begin
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  err_q   <= oor;
                  state_q <= ST_DONE;
                  if (!wr_q) begin
                     rdata_q <= oor ? 32'd0 : rd_word;
                  end
               end
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   // Storage has no reset so contents survive a reset pulse.
   always_ff @(posedge clk) begin
      if (commit) begin
         for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
               mem_q[idx[i]] <= wdata_q[8*i +: 8];
            end
         end
      end
   end

   assign bus.rdata = rdata_q;
   assign bus.busy  = busy_q;
   assign bus.done  = done_q;
   assign bus.err   = err_q;

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter LATENCY, default 2, cycles from request acceptance to completion; legal range 1..15.
REQ-002 SHALL have port clk, input, 1, rising-edge clock for all state.
REQ-003 SHALL have port reset, input, 1; reset is synchronous and active-high, sampled on the clk rising edge.
REQ-004 SHALL have port req, input, 1, access request; sampled only while busy=0.
REQ-005 SHALL have port wr, input, 1: 1 = write, 0 = read. Captured with req.
REQ-006 SHALL have port size, input, 2, write width: 00 word, 01 half, 10 byte, 11 word. Captured with req.
REQ-007 SHALL have port addr, input, 32, byte address. Captured with req.
REQ-008 SHALL have port wdata, input, 32, write data. Captured with req.
REQ-009 SHALL have port rdata, output, 32, read word, registered.
REQ-010 SHALL have port busy, output, 1, high while an access is in flight.
REQ-011 SHALL have port done, output, 1, single-cycle completion pulse.
REQ-012 SHALL have port err, output, 1, out-of-range flag; valid only while done=1.

Function
REQ-013 SHALL hold 256 bytes of storage, indexed by addr[7:0].
REQ-014 SHALL use little-endian words: the byte at address a maps to bits 7:0, a+1 to 15:8, a+2 to 23:16, a+3 to 31:24.
REQ-015 SHALL compute byte indices modulo 256, so that address 254 wraps to bytes 254, 255, 0, 1.
REQ-016 SHALL accept unaligned addresses with no alignment fault.
REQ-017 SHALL implement FSM states IDLE, WAIT and DONE; busy=1 only in WAIT; done=1 only in DONE.
REQ-018 SHALL, in IDLE or DONE with req=1 at an edge: capture wr/size/addr/wdata, load the counter with LATENCY-1, and go to WAIT.
REQ-019 SHALL, in DONE with req=0, go to IDLE; back-to-back requests give one access per LATENCY+1 cycles.
REQ-020 SHALL, in WAIT with counter>0, decrement the counter; with counter=0, go to DONE at that edge.
REQ-021 SHALL ignore req while in WAIT; no queuing and no effect on the in-flight access.
REQ-022 SHALL make done rise on edge k+LATENCY when the request was accepted on edge k.
REQ-023 SHALL commit a write to storage on the same edge that enters DONE, and not earlier.
REQ-024 SHALL, for size 00/11, write all 4 bytes.
REQ-025 SHALL, for size 01, write wdata[15:0] to bytes a and a+1 only.
REQ-026 SHALL, for size 10, write wdata[7:0] to byte a only.
REQ-027 SHALL, for a read, load rdata with the 4-byte word at the captured address on the edge that enters DONE.
REQ-028 SHALL hold rdata until the next read completion; writes SHALL NOT change rdata.
REQ-029 SHALL treat captured addr[31:8] != 0 as out of range: set err=1 with done, perform no write, and on a read load rdata = 0.
REQ-030 SHALL drive err=0 whenever done=0.
REQ-031 SHALL return the newly written bytes to a read issued immediately after a write completes; read-after-write is coherent.

Reset
REQ-032 SHALL, with reset=1 at an edge, enter IDLE and clear the counter and captured request; busy, done, err and rdata SHALL read 0 after that edge.
REQ-033 SHALL, on reset asserted in WAIT, abort the access: no write is committed and no done pulse occurs.
REQ-034 SHALL give reset priority over req at the same edge, so the request is dropped.
REQ-035 SHALL NOT have reset alter storage contents.

Verification
REQ-036 Write/read, LATENCY=2: req wr=1 size=00 addr=0x10 wdata=0xA1B2C3D4 on edge 0 -> done on edge 2; then read 0x10 -> rdata=0xA1B2C3D4, byte 0x10 = 0xD4.
REQ-037 Partial writes: word 0xFFFFFFFF at 0x20, then half 0x1234 at 0x20, then byte 0x56 at 0x23 -> read 0x20 returns 0x56FF1234.
REQ-038 Wrap-around: word 0x11223344 written at 0xFE -> bytes 0xFE=0x44, 0xFF=0x33, 0x00=0x22, 0x01=0x11; read 0xFE returns 0x11223344.
REQ-039 Error and ignore: write to 0x00000100 -> done=1, err=1, byte 0x00 unchanged; a req pulsed mid-WAIT produces no second done.
REQ-040 Reset mid-op: write 0xDEADBEEF at 0x40 with reset on edge 1 -> busy=done=0, next read 0x40 returns its prior value.
REQ-041 Back-to-back and latency sweep: req held high with LATENCY=1 -> done every 2 cycles; LATENCY=15 -> done exactly 15 edges after acceptance.
